ofm_wb_scheduler: RTL and testbench

//  Sequences the OFM write-back of one layer: splits the layer's output into NUM_TILES bursts,

---
 rtl/ofm_wb_scheduler.sv | 151 +++++++++++++++
 tb/tb_ofm_wb_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_wb_scheduler.sv
// OFM write-back scheduler: ping-pongs two OFM banks and launches one AXI write burst per tile.
// Optional build macro OFM_WB_PERF_CNT_EN adds stall/write cycle performance counters.
module ofm_wb_scheduler #(
  parameter int AXI_ADDR_W = 32,
  parameter int TILE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [AXI_ADDR_W-1:0] cfg_base_addr,
  input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
  input  logic [AXI_ADDR_W-1:0] cfg_tile_stride,
  input  logic [1:0]            bank_full,
  output logic [1:0]            bank_release,
  output logic                  wr_start,
  output logic [AXI_ADDR_W-1:0] wr_base_addr,
  output logic                  wr_bank_sel,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  err_spurious
`ifdef OFM_WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_wr_cyc
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BANK, S_ISSUE, S_WAIT_DONE, S_RELEASE, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_ADDR_W-1:0] stride_q, stride_d;
  logic [TILE_CNT_W-1:0] num_q, num_d;
  logic [TILE_CNT_W-1:0] tile_idx_q, tile_idx_d;
  logic                  bank_q, bank_d;
  logic                  err_q, err_d;
  logic                  cfg_acc;
  logic                  last_tile;

  assign cfg_acc   = (state_q == S_IDLE) && cfg_valid;
  // num_q is at least 1 whenever RELEASE is reachable, so num_q-1 never underflows
  assign last_tile = (tile_idx_q == (num_q - TILE_CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tile_idx_q <= '0;
      bank_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tile_idx_q <= tile_idx_d;
      bank_q     <= bank_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    num_q    <= num_d;
    stride_q <= stride_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cfg_valid) state_d = (cfg_num_tiles == '0) ? S_FINISH : S_WAIT_BANK;
      S_WAIT_BANK: if (bank_full[bank_q]) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (wr_done) state_d = S_RELEASE;
      S_RELEASE:   state_d = last_tile ? S_FINISH : S_WAIT_BANK;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    stride_d   = stride_q;
    num_d      = num_q;
    tile_idx_d = tile_idx_q;
    bank_d     = bank_q;
    err_d      = err_q;
    if (cfg_acc) begin
      addr_d     = cfg_base_addr;
      stride_d   = cfg_tile_stride;
      num_d      = cfg_num_tiles;
      tile_idx_d = '0;
      bank_d     = 1'b0;
      err_d      = 1'b0;
    end else if (state_q == S_RELEASE) begin
      addr_d     = addr_q + stride_q;
      bank_d     = ~bank_q;
      tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
    end
    // a stray completion is flagged even if it coincides with a config accept
    if (wr_done && (state_q != S_WAIT_DONE)) err_d = 1'b1;
  end

  always_comb begin
    cfg_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    wr_start     = (state_q == S_ISSUE);
    layer_done   = (state_q == S_FINISH);
    bank_release = 2'b00;
    if (state_q == S_RELEASE) bank_release[bank_q] = 1'b1;
    wr_base_addr = addr_q;
    wr_bank_sel  = bank_q;
    err_spurious = err_q;
  end

`ifdef OFM_WB_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] wrc_q, wrc_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    wrc_d   = wrc_q;
    if (cfg_acc) begin
      stall_d = '0;
      wrc_d   = '0;
    end else begin
      if (state_q == S_WAIT_BANK) stall_d = sat_inc(stall_q);
      if (state_q == S_WAIT_DONE) wrc_d   = sat_inc(wrc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      wrc_q   <= '0;
    end else begin
      stall_q <= stall_d;
      wrc_q   <= wrc_d;
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_wr_cyc    = wrc_q;
`endif

endmodule

// File: tb/tb_ofm_wb_scheduler.sv
// Self-checking bench for ofm_wb_scheduler: models the PE array and write master, and compares
// observed bursts/releases against addresses and banks computed directly from the layer config.
module tb_ofm_wb_scheduler;
  localparam int AW  = 32;
  localparam int TW  = 16;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [TW-1:0] cfg_num_tiles = '0;
  logic [AW-1:0] cfg_tile_stride = '0;
  logic [1:0]    bank_full = 2'b00;
  logic [1:0]    bank_release;
  logic          wr_start;
  logic [AW-1:0] wr_base_addr;
  logic          wr_bank_sel;
  logic          wr_done = 1'b0;
  logic          busy, layer_done, err_spurious;
`ifdef OFM_WB_PERF_CNT_EN
  logic [31:0]   perf_stall_cyc, perf_wr_cyc;
`endif

  always #5 clk = ~clk;

  ofm_wb_scheduler #(.AXI_ADDR_W(AW), .TILE_CNT_W(TW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_addr(cfg_base_addr), .cfg_num_tiles(cfg_num_tiles), .cfg_tile_stride(cfg_tile_stride),
    .bank_full(bank_full), .bank_release(bank_release), .wr_start(wr_start),
    .wr_base_addr(wr_base_addr), .wr_bank_sel(wr_bank_sel), .wr_done(wr_done),
    .busy(busy), .layer_done(layer_done), .err_spurious(err_spurious)
`ifdef OFM_WB_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_wr_cyc(perf_wr_cyc)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wm_cnt = 0, wm_lat = 1, spur_at = -1;
  int ready_at [2];
  int refill_dly [2];
  logic [1:0] pe_full = 2'b00;

  logic [AW-1:0] st_addr [$];
  int st_bank [$], st_cyc [$], rel_bank [$], rel_cyc [$];
  int ld_cnt, ld_cyc, stab_bad, acc_cyc, bad_rel;
  logic [AW-1:0] prev_addr = '0, hold_addr = '0;
  logic prev_bank = 1'b0, hold_bank = 1'b0, in_burst = 1'b0;

  // Tile k lives at base + k*stride, truncated to the address width.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int k);
    logic [63:0] x;
    x = 64'(b) + 64'(s) * 64'(k);
    return x[AW-1:0];
  endfunction

  task automatic clear_rec();
    st_addr.delete(); st_bank.delete(); st_cyc.delete(); rel_bank.delete(); rel_cyc.delete();
    ld_cnt = 0; ld_cyc = -1; stab_bad = 0; bad_rel = 0; in_burst = 1'b0; spur_at = -1;
  endtask

  task automatic prefill(input logic [1:0] full);
    pe_full = full;
    ready_at[0] = full[0] ? 0 : BIG;
    ready_at[1] = full[1] ? 0 : BIG;
    bank_full = pe_full;
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge, then drive the models.
  task automatic step();
    logic done_n;
    int b;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin wm_cnt = 0; in_burst = 1'b0; end
    if (wr_start) begin
      if (wr_base_addr !== prev_addr || wr_bank_sel !== prev_bank) stab_bad++;
      st_addr.push_back(wr_base_addr); st_bank.push_back(int'(wr_bank_sel)); st_cyc.push_back(cyc);
      hold_addr = wr_base_addr; hold_bank = wr_bank_sel; in_burst = 1'b1;
    end
    if (in_burst && (wr_base_addr !== hold_addr || wr_bank_sel !== hold_bank)) stab_bad++;
    if (bank_release != 2'b00) begin
      if (bank_release == 2'b11) bad_rel++;
      b = bank_release[1] ? 1 : 0;
      rel_bank.push_back(b); rel_cyc.push_back(cyc); in_burst = 1'b0;
      pe_full[b] = 1'b0; ready_at[b] = cyc + refill_dly[b];
    end
    if (layer_done) begin ld_cnt++; ld_cyc = cyc; end
    done_n = 1'b0;
    if (wm_cnt > 0) begin wm_cnt--; if (wm_cnt == 0) done_n = 1'b1; end
    if (wr_start) wm_cnt = wm_lat;
    if (cyc == spur_at) done_n = 1'b1;
    wr_done = done_n;
    for (int i = 0; i < 2; i++) if (!pe_full[i] && cyc >= ready_at[i]) pe_full[i] = 1'b1;
    bank_full = pe_full;
    prev_addr = wr_base_addr; prev_bank = wr_bank_sel;
  endtask

  task automatic start_layer(input logic [AW-1:0] base, input int num, input logic [AW-1:0] stride);
    cfg_base_addr = base; cfg_num_tiles = TW'(num); cfg_tile_stride = stride;
    cfg_valid = 1'b1;
    step();
    acc_cyc = cyc;
    cfg_valid = 1'b0;
    cfg_base_addr = $urandom; cfg_num_tiles = TW'($urandom); cfg_tile_stride = $urandom;
  endtask

  task automatic run_to_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (ld_cnt > 0) begin to = 1'b0; break; end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || wr_start !== 1'b0 || bank_release !== 2'b00 ||
        wr_base_addr !== '0 || wr_bank_sel !== 1'b0 || layer_done !== 1'b0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b st=%b rel=%b addr=%h sel=%b ld=%b err=%b want 1 0 0 00 0 0 0 0",
               cfg_ready, busy, wr_start, bank_release, wr_base_addr, wr_bank_sel, layer_done, err_spurious);
    end
`ifdef OFM_WB_PERF_CNT_EN
    checks++;
    if (perf_stall_cyc !== 32'd0 || perf_wr_cyc !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cyc, perf_wr_cyc);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit to;
    logic [AW-1:0] base = 32'h1000_0000, stride = 32'h800;
    clear_rec(); prefill(2'b11); refill_dly = '{0, 0}; wm_lat = 10;
    start_layer(base, 4, stride);
    run_to_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout want layer_done"); end
    checks++; if (st_addr.size() != 4) begin errors++; $display("FAIL basic_starts: got %0d want 4", st_addr.size()); end
    for (int k = 0; k < 4 && k < st_addr.size(); k++) begin
      checks++;
      if (st_addr[k] !== exp_addr(base, stride, k) || st_bank[k] != (k % 2)) begin
        errors++; $display("FAIL basic_tile%0d: got addr=%h bank=%0d want addr=%h bank=%0d",
                           k, st_addr[k], st_bank[k], exp_addr(base, stride, k), k % 2);
      end
    end
    checks++; if (rel_bank.size() != 4) begin errors++; $display("FAIL basic_releases: got %0d want 4", rel_bank.size()); end
    for (int k = 0; k < 4 && k < rel_bank.size(); k++) begin
      checks++; if (rel_bank[k] != (k % 2)) begin errors++; $display("FAIL basic_rel%0d: got %0d want %0d", k, rel_bank[k], k % 2); end
    end
    checks++; if (ld_cnt != 1) begin errors++; $display("FAIL basic_layer_done: got %0d want 1", ld_cnt); end
    checks++; if (stab_bad != 0 || bad_rel != 0) begin errors++; $display("FAIL basic_stable: got %0d/%0d want 0/0", stab_bad, bad_rel); end
    if (st_cyc.size() > 0 && rel_cyc.size() == 4) begin
      checks++; if (st_cyc[0] != acc_cyc + 1) begin errors++; $display("FAIL basic_start_lat: got %0d want %0d", st_cyc[0] - acc_cyc, 1); end
      checks++; if (rel_cyc[0] != st_cyc[0] + wm_lat + 1) begin errors++; $display("FAIL basic_rel_lat: got %0d want %0d", rel_cyc[0] - st_cyc[0], wm_lat + 1); end
      checks++; if (ld_cyc != rel_cyc[3] + 1) begin errors++; $display("FAIL basic_ld_lat: got %0d want %0d", ld_cyc, rel_cyc[3] + 1); end
    end
`ifdef OFM_WB_PERF_CNT_EN
    checks++; if (perf_wr_cyc !== 32'(4 * wm_lat)) begin errors++; $display("FAIL basic_perf_wr: got %0d want %0d", perf_wr_cyc, 4 * wm_lat); end
`endif
  endtask

  task automatic test_empty();
    bit to;
    clear_rec(); prefill(2'b11);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", cfg_ready); end
    start_layer(32'h2000_0000, 0, 32'h40);
    checks++; if (busy !== 1'b1 || layer_done !== 1'b1) begin errors++; $display("FAIL empty_finish: got busy=%b ld=%b want 1 1", busy, layer_done); end
    run_to_done(10, to);
    checks++; if (to || ld_cyc != acc_cyc || ld_cnt != 1) begin errors++; $display("FAIL empty_ld: got cyc=%0d cnt=%0d want cyc=%0d cnt=1", ld_cyc, ld_cnt, acc_cyc); end
    checks++; if (st_addr.size() != 0 || rel_bank.size() != 0) begin errors++; $display("FAIL empty_no_burst: got %0d starts %0d rels want 0 0", st_addr.size(), rel_bank.size()); end
    checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL empty_idle: got busy=%b rdy=%b want 0 1", busy, cfg_ready); end
  endtask

  task automatic test_stall();
    bit to;
    clear_rec(); prefill(2'b01); refill_dly = '{0, 0}; wm_lat = 5;
    start_layer(32'h3000_0000, 2, 32'h100);
    for (int i = 0; i < 100 && rel_cyc.size() == 0; i++) step();
    ready_at[1] = cyc + 50;
    run_to_done(300, to);
    checks++; if (to || st_cyc.size() != 2 || rel_cyc.size() != 2) begin errors++; $display("FAIL stall_seq: got to=%0d starts=%0d rels=%0d want 0 2 2", to, st_cyc.size(), rel_cyc.size()); end
    if (st_cyc.size() == 2 && rel_cyc.size() > 0) begin
      checks++; if (st_cyc[1] != rel_cyc[0] + 51) begin errors++; $display("FAIL stall_gap: got %0d want %0d", st_cyc[1] - rel_cyc[0], 51); end
      checks++; if (st_bank[1] != 1 || st_addr[1] !== 32'h3000_0100) begin errors++; $display("FAIL stall_tile1: got bank=%0d addr=%h want 1 30000100", st_bank[1], st_addr[1]); end
    end
`ifdef OFM_WB_PERF_CNT_EN
    checks++; if (perf_stall_cyc < 32'd50) begin errors++; $display("FAIL stall_perf: got %0d want >=50", perf_stall_cyc); end
`endif
  endtask

  task automatic test_wrap();
    bit to;
    logic [AW-1:0] want [3] = '{32'hFFFF_F800, 32'h0000_0000, 32'h0000_0800};
    clear_rec(); prefill(2'b11); refill_dly = '{1, 2}; wm_lat = 3;
    start_layer(32'hFFFF_F800, 3, 32'h800);
    run_to_done(200, to);
    checks++; if (to || st_addr.size() != 3) begin errors++; $display("FAIL wrap_seq: got to=%0d starts=%0d want 0 3", to, st_addr.size()); end
    for (int k = 0; k < 3 && k < st_addr.size(); k++) begin
      checks++; if (st_addr[k] !== want[k]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", k, st_addr[k], want[k]); end
    end
  endtask

  task automatic test_spurious();
    bit to;
    clear_rec(); prefill(2'b01); refill_dly = '{0, 0}; wm_lat = 3;
    start_layer(32'h4000_0000, 2, 32'h20);
    for (int i = 0; i < 100 && rel_cyc.size() == 0; i++) step();
    ready_at[1] = cyc + 30;
    spur_at = cyc + 3;
    run_to_done(200, to);
    checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_flag: got %b want 1", err_spurious); end
    checks++;
    if (to || st_addr.size() != 2 || rel_bank.size() != 2 || ld_cnt != 1) begin
      errors++; $display("FAIL spur_seq: got to=%0d starts=%0d rels=%0d ld=%0d want 0 2 2 1", to, st_addr.size(), rel_bank.size(), ld_cnt);
    end else if (st_addr[1] !== exp_addr(32'h4000_0000, 32'h20, 1) || st_bank[1] != 1) begin
      errors++; $display("FAIL spur_seq: got tile1 addr=%h bank=%0d want %h 1", st_addr[1], st_bank[1], exp_addr(32'h4000_0000, 32'h20, 1));
    end
    clear_rec(); prefill(2'b11);
    start_layer(32'h5000_0000, 1, 32'h20);
    checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL spur_clear: got %b want 0", err_spurious); end
    run_to_done(100, to);
    checks++; if (to || st_addr.size() != 1 || rel_bank.size() != 1 || err_spurious !== 1'b0) begin
      errors++; $display("FAIL single_tile: got to=%0d starts=%0d rels=%0d err=%b want 0 1 1 0", to, st_addr.size(), rel_bank.size(), err_spurious);
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    logic [AW-1:0] base2;
    clear_rec(); prefill(2'b11); refill_dly = '{0, 0}; wm_lat = 20;
    start_layer(32'h6000_0000, 4, 32'h1000);
    for (int i = 0; i < 300 && st_cyc.size() < 3; i++) step();
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || wr_start !== 1'b0 || bank_release !== 2'b00 ||
        wr_base_addr !== '0 || wr_bank_sel !== 1'b0 || layer_done !== 1'b0 || err_spurious !== 1'b0 || st_cyc.size() != 3) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy=%b busy=%b st=%b rel=%b addr=%h sel=%b ld=%b err=%b starts=%0d want 1 0 0 00 0 0 0 0 3",
               cfg_ready, busy, wr_start, bank_release, wr_base_addr, wr_bank_sel, layer_done, err_spurious, st_cyc.size());
    end
    rst = 1'b0;
    step();
    clear_rec(); prefill(2'b11); wm_lat = 4;
    base2 = $urandom;
    start_layer(base2, 2, 32'h80);
    run_to_done(100, to);
    checks++;
    if (to || st_addr.size() != 2 || st_bank[0] != 0 || st_addr[0] !== base2 || rel_bank.size() != 2 || ld_cnt != 1) begin
      errors++; $display("FAIL midrst_restart: got to=%0d starts=%0d first=%h want 0 2 %h", to, st_addr.size(),
                         (st_addr.size() > 0) ? st_addr[0] : '0, base2);
    end
  endtask

  task automatic test_random();
    bit to;
    logic [AW-1:0] base, stride;
    int num, bad;
    for (int r = 0; r < 8; r++) begin
      base = $urandom; stride = $urandom; num = $urandom_range(1, 6);
      wm_lat = $urandom_range(1, 8);
      refill_dly = '{$urandom_range(0, 5), $urandom_range(0, 5)};
      clear_rec(); prefill(2'($urandom_range(0, 3)));
      if (pe_full[0] == 1'b0) ready_at[0] = cyc + $urandom_range(1, 6);
      if (pe_full[1] == 1'b0) ready_at[1] = cyc + $urandom_range(1, 6);
      start_layer(base, num, stride);
      run_to_done(500, to);
      bad = 0;
      if (st_addr.size() != num || rel_bank.size() != num) bad++;
      for (int k = 0; k < num && k < st_addr.size(); k++)
        if (st_addr[k] !== exp_addr(base, stride, k) || st_bank[k] != (k % 2)) bad++;
      for (int k = 0; k < num && k < rel_bank.size(); k++)
        if (rel_bank[k] != (k % 2)) bad++;
      checks++;
      if (to || bad != 0 || ld_cnt != 1 || stab_bad != 0 || bad_rel != 0) begin
        errors++; $display("FAIL random%0d: got to=%0d badtiles=%0d starts=%0d ld=%0d unstable=%0d want 0 0 %0d 1 0",
                           r, to, bad, st_addr.size(), ld_cnt, stab_bad, num);
      end
`ifdef OFM_WB_PERF_CNT_EN
      checks++; if (perf_wr_cyc !== 32'(num * wm_lat)) begin errors++; $display("FAIL random%0d_perf_wr: got %0d want %0d", r, perf_wr_cyc, num * wm_lat); end
`endif
    end
  endtask

  initial begin
    refill_dly = '{0, 0};
    ready_at = '{BIG, BIG};
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_wrap();
    test_spurious();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
